key_pio_edge: RTL and testbench
===============================

// Module: key_pio_edge
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons and switches. Next generation of the
//  plain read-only key port: adds synchronisation, per-channel debounce, edge capture,
//  per-bit interrupt mask and an IRQ line. Sits between board pins and the Nios II bus.
// PARAMETERS
//  WIDTH            4      number of input channels
//  SYNC_STAGES      2      synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  50000  clocks an input must be stable before it is accepted (>=1)
//  EDGE_TYPE        0      captured edge: 0 falling (key press), 1 rising, 2 any
//  IDLE_LEVEL       1      idle pin level; reset value of sync/debounce flops
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      reset, asynchronous, active-low
//  address    in   2      Avalon word address
//  write_n    in   1      Avalon write strobe, active-low
//  writedata  in   WIDTH  Avalon write data
//  readdata   out  WIDTH  Avalon read data, registered
//  irq        out  1      interrupt request, active-high level
//  in_port    in   WIDTH  raw asynchronous pin inputs
// BEHAVIOUR
//  Register map (read latency 1 clk, readdata reset 0; no waitstates):
//   0 DATA     RO  debounced input levels; writes ignored
//   1 -        RO  reads 0
//   2 IRQMASK  RW  reset 0; bit=1 enables that channel's IRQ
//   3 EDGECAP  RW1C reset 0; write bit=1 clears that bit, bit=0 leaves it
//  Per-channel pipeline: in_port -> SYNC_STAGES flops -> debounce -> edge detect.
//  Debounce: counter resets to 0 whenever synced value equals accepted value; otherwise
//   increments; at DEBOUNCE_CYCLES-1 the accepted value takes the synced value and
//   counter clears. Glitch shorter than DEBOUNCE_CYCLES clocks -> no change.
//  Counter width = $clog2(DEBOUNCE_CYCLES+1); no wrap possible.
//  Edge detect: compares accepted value to its 1-clk delayed copy; EDGE_TYPE selects.
//  Latency pin change -> DATA/EDGECAP update: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clks.
//  EDGECAP bit is sticky until cleared by software.
//  Simultaneous edge and W1C on same bit, same cycle: set wins (bit stays 1).
//  irq = |(EDGECAP & IRQMASK), from registers, no extra delay; reset 0.
//  Reset (any time, incl. mid-debounce): counters 0, sync/accepted/delayed flops to
//   IDLE_LEVEL, so no edge is captured on reset release while pins are idle.
//  Read of EDGECAP in the same cycle as a set returns the pre-set value.
// STRUCTURE
//  Package key_pio_pkg: address constants ADDR_DATA/ADDR_MASK/ADDR_EDGE, EDGE_* enum.
//  Sub-module key_debounce (one channel: synchroniser + counter + accepted flop),
//   instantiated WIDTH times via generate; top holds bus regs, edge logic, irq.
// TESTING (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_TYPE=0)
//  1 Reset, pins 4'hF -> readdata 0, irq 0; read addr0 -> 4'hF, addr3 -> 0.
//  2 in_port[0] to 0 held 10 clks -> DATA 4'hE after 7 clks; EDGECAP 4'h1; irq 0 (mask 0).
//  3 Write IRQMASK 4'h1 with EDGECAP=1 -> irq 1 next clk; write addr3 4'h1 -> irq 0.
//  4 in_port[1] pulsed 0 for 3 clks -> DATA, EDGECAP unchanged (glitch rejected).
//  5 Edge on bit2 same clk as W1C 4'h4 -> EDGECAP[2] stays 1.
//  6 Assert reset_n mid-debounce, release with pins idle -> EDGECAP 0, irq 0, DATA 4'hF.

Source files
------------

// File: rtl/key_pio_pkg.sv
// key_pio_pkg: register map and edge-select encodings for the key PIO
package key_pio_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    typedef enum logic [1:0] {
        EDGE_FALL = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_e;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one channel of pin synchroniser, stability counter and accepted level
module key_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;
    assign synced = sync[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync  <= {SYNC_STAGES{IDLE_LEVEL}};
            cnt   <= '0;
            level <= IDLE_LEVEL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (synced == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= synced;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/key_pio_edge.sv
// key_pio_edge: Avalon-MM input PIO with debounce, edge capture, mask and IRQ
module key_pio_edge
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    logic [WIDTH-1:0] level, level_d, edge_cap, irq_mask, edge_hit, clr;
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        key_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[g]),
            .level  (level[g])
        );
    end
    always_comb begin
        edge_hit = EDGE_TYPE == int'(EDGE_FALL) ? level_d & ~level :
                   EDGE_TYPE == int'(EDGE_RISE) ? ~level_d & level : level_d ^ level;
        clr = (!write_n && address == ADDR_EDGE) ? writedata : '0;
    end
    // a new edge is OR-ed in after the clear so it survives a coincident W1C
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            level_d  <= {WIDTH{IDLE_LEVEL}};
            edge_cap <= '0;
            irq_mask <= '0;
            readdata <= '0;
        end else begin
            level_d  <= level;
            edge_cap <= (edge_cap & ~clr) | edge_hit;
            if (!write_n && address == ADDR_MASK)
                irq_mask <= writedata;
            readdata <= address == ADDR_DATA ? level :
                        address == ADDR_MASK ? irq_mask :
                        address == ADDR_EDGE ? edge_cap : '0;
        end
    assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_key_pio_edge.sv
// tb_key_pio_edge: directed and randomized checks of key_pio_edge against a window-based model
module tb_key_pio_edge;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         write_n = 1'b1;
    logic [W-1:0] writedata = '0;
    logic [W-1:0] in_port = 4'hF;
    logic [W-1:0] readdata;
    logic         irq;
    int n_vec = 0;
    int n_err = 0;
    // model: a level is accepted once the last DC synchronised samples all disagree with it
    logic [W-1:0] q[$];
    logic [W-1:0] m_acc, m_prev, m_edge, m_mask, m_rd;
    logic         m_irq;

    always #5 clk = ~clk;

    key_pio_edge #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq), .in_port(in_port)
    );

    task automatic model_reset();
        q.delete();
        repeat (SS + DC) q.push_back(4'hF);
        m_acc = 4'hF; m_prev = 4'hF; m_edge = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    endtask

    task automatic step();
        logic [W-1:0] nacc, fall, clr;
        bit flip;
        if (!reset_n) begin
            model_reset();
            return;
        end
        q.push_front(in_port);
        void'(q.pop_back());
        nacc = m_acc;
        for (int c = 0; c < W; c++) begin
            flip = 1'b1;
            for (int k = SS; k < SS + DC; k++)
                if (q[k][c] == m_acc[c]) flip = 1'b0;
            if (flip) nacc[c] = ~m_acc[c];
        end
        fall = m_prev & ~m_acc;
        clr  = (!write_n && address == 2'd3) ? writedata : '0;
        m_rd = address == 2'd0 ? m_acc : address == 2'd2 ? m_mask : address == 2'd3 ? m_edge : '0;
        m_edge = (m_edge & ~clr) | fall;
        if (!write_n && address == 2'd2) m_mask = writedata;
        m_prev = m_acc;
        m_acc  = nacc;
        m_irq  = |(m_edge & m_mask);
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            step();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_port = 4'hF;
        model_reset();
        cycle(2);
        n_vec++;
        if (readdata !== 4'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: readdata=%h irq=%b, required 0/0", readdata, irq);
        end
        reset_n = 1'b1;
        address = 2'd0;
        cycle(1);
        n_vec++;
        if (readdata !== 4'hF) begin
            n_err++;
            $display("FAIL reset_data: readdata=%h, required F", readdata);
        end
        address = 2'd3;
        cycle(1);
        n_vec++;
        if (readdata !== 4'h0) begin
            n_err++;
            $display("FAIL reset_edgecap: readdata=%h, required 0", readdata);
        end
    endtask

    task automatic test_debounce();
        in_port = 4'hE;
        address = 2'd0;
        cycle(6);
        n_vec++;
        if (readdata !== 4'hF) begin
            n_err++;
            $display("FAIL debounce_early: readdata=%h, required F", readdata);
        end
        cycle(1);
        n_vec++;
        if (readdata !== 4'hE) begin
            n_err++;
            $display("FAIL debounce_latency: readdata=%h, required E", readdata);
        end
        cycle(3);
        address = 2'd3;
        cycle(1);
        n_vec++;
        if (readdata !== 4'h1 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL debounce_edgecap: readdata=%h irq=%b, required 1/0", readdata, irq);
        end
    endtask

    task automatic test_irq();
        address = 2'd2; writedata = 4'h1; write_n = 1'b0;
        cycle(1);
        write_n = 1'b1;
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_set: irq=%b, required 1", irq);
        end
        address = 2'd3; writedata = 4'h1; write_n = 1'b0;
        cycle(1);
        write_n = 1'b1;
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
        address = 2'd2;
        cycle(1);
        n_vec++;
        if (readdata !== 4'h1) begin
            n_err++;
            $display("FAIL irq_mask_read: readdata=%h, required 1", readdata);
        end
    endtask

    task automatic test_glitch();
        in_port = 4'hC;
        cycle(3);
        in_port = 4'hE;
        address = 2'd0;
        cycle(10);
        n_vec++;
        if (readdata !== 4'hE || readdata !== m_rd) begin
            n_err++;
            $display("FAIL glitch_data: readdata=%h, required E (model %h)", readdata, m_rd);
        end
        address = 2'd3;
        cycle(1);
        n_vec++;
        if (readdata !== 4'h0) begin
            n_err++;
            $display("FAIL glitch_edgecap: readdata=%h, required 0", readdata);
        end
    endtask

    task automatic test_set_wins();
        in_port = 4'hA;
        address = 2'd3;
        cycle(6);
        writedata = 4'h4; write_n = 1'b0;
        cycle(1);
        write_n = 1'b1;
        n_vec++;
        if (readdata !== 4'h0) begin
            n_err++;
            $display("FAIL set_read_preset: readdata=%h, required 0", readdata);
        end
        cycle(1);
        n_vec++;
        if (readdata !== 4'h4 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL set_wins: readdata=%h irq=%b, required 4/0", readdata, irq);
        end
    endtask

    task automatic test_reset_mid();
        in_port = 4'hF;
        cycle(10);
        in_port = 4'h0;
        cycle(3);
        reset_n = 1'b0;
        cycle(2);
        in_port = 4'hF;
        reset_n = 1'b1;
        address = 2'd0;
        cycle(10);
        n_vec++;
        if (readdata !== 4'hF || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_data: readdata=%h irq=%b, required F/0", readdata, irq);
        end
        address = 2'd3;
        cycle(1);
        n_vec++;
        if (readdata !== 4'h0) begin
            n_err++;
            $display("FAIL reset_mid_edgecap: readdata=%h, required 0", readdata);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 60; s++) begin
            in_port = W'($urandom);
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                address   = 2'($urandom);
                write_n   = ($urandom_range(0, 3) != 0);
                writedata = W'($urandom);
                cycle(1);
                write_n = 1'b1;
                n_vec++;
                if (readdata !== m_rd || irq !== m_irq) begin
                    n_err++;
                    $display("FAIL random seg%0d: readdata=%h irq=%b, required %h/%b",
                             s, readdata, irq, m_rd, m_irq);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_irq();
        test_glitch();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
